// File: rtl/pp_task_monitor_if.sv
// Controller-facing start/busy/irq handshake bundle observed by pp_task_monitor,
// together with the monitor's registered status outputs.
interface pp_task_monitor_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16,
    parameter int LAT_W  = 12
);
    logic [NUM_CH-1:0]       ch_start_i;
    logic [NUM_CH-1:0]       ch_busy_i;
    logic [NUM_CH-1:0]       ch_irq_i;
    logic [NUM_CH-1:0]       err_clr_i;
    logic [NUM_CH-1:0]       ch_active_o;
    logic [NUM_CH-1:0]       ch_err_o;
    logic [3*NUM_CH-1:0]     ch_err_code_o;
    logic [CNT_W*NUM_CH-1:0] done_cnt_o;
    logic [LAT_W*NUM_CH-1:0] last_lat_o;
    logic                    any_err_o;

    modport master (
        output ch_start_i, ch_busy_i, ch_irq_i, err_clr_i,
        input  ch_active_o, ch_err_o, ch_err_code_o, done_cnt_o, last_lat_o, any_err_o
    );

    modport slave (
        input  ch_start_i, ch_busy_i, ch_irq_i, err_clr_i,
        output ch_active_o, ch_err_o, ch_err_code_o, done_cnt_o, last_lat_o, any_err_o
    );
endinterface

// File: rtl/pp_task_monitor.sv
// Per-channel start/busy/irq protocol monitor: lifecycle FSM, sticky first-error
// code, wrapping done counter and saturating start-to-irq latency.
module pp_task_monitor #(
    parameter int NUM_CH   = 3,
    parameter int START_TO = 8,
    parameter int RUN_TO   = 1024,
    parameter int CNT_W    = 16,
    parameter int LAT_W    = 12
) (
    input  logic             clk,
    input  logic             reset,
    pp_task_monitor_if.slave mon
);
    localparam int TMAX  = (START_TO > RUN_TO) ? START_TO : RUN_TO;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam logic [TMR_W-1:0] START_LIM = TMR_W'(START_TO);
    localparam logic [TMR_W-1:0] RUN_LIM   = TMR_W'(RUN_TO);
    localparam logic [LAT_W-1:0] LAT_MAX   = {LAT_W{1'b1}};

    localparam logic [2:0] E_START_ACT  = 3'd1;
    localparam logic [2:0] E_BUSY_TO    = 3'd2;
    localparam logic [2:0] E_RUN_TO     = 3'd3;
    localparam logic [2:0] E_SPUR_IRQ   = 3'd4;
    localparam logic [2:0] E_BUSY_DROP  = 3'd5;
    localparam logic [2:0] E_UNSOL_BUSY = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BUSY, S_FAULT} state_t;

    logic [NUM_CH-1:0] w_err_nx;
    logic              r_any;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            state_t           r_state, w_state;
            logic [TMR_W-1:0] r_tmr, w_tmr, w_tinc;
            logic [LAT_W-1:0] r_lat, w_lat, w_linc, r_last;
            logic [CNT_W-1:0] r_cnt;
            logic [2:0]       r_code, w_code;
            logic             r_grace, w_grace, w_done, r_err, r_act;
            logic             w_st, w_bz, w_iq, w_clr;

            assign w_st   = mon.ch_start_i[g];
            assign w_bz   = mon.ch_busy_i[g];
            assign w_iq   = mon.ch_irq_i[g];
            assign w_clr  = mon.err_clr_i[g];
            assign w_tinc = r_tmr + TMR_W'(1);
            assign w_linc = (r_lat == LAT_MAX) ? r_lat : r_lat + LAT_W'(1);

            // Within each state the checks are ordered by code, so the lowest code wins.
            always_comb begin
                w_state = r_state;
                w_tmr   = r_tmr;
                w_lat   = r_lat;
                w_code  = r_code;
                w_grace = 1'b0;
                w_done  = 1'b0;
                if (w_clr) begin
                    w_state = S_IDLE;
                    w_code  = 3'd0;
                    w_tmr   = '0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_iq) begin
                                w_state = S_FAULT;
                                w_code  = E_SPUR_IRQ;
                            end else if (w_bz && !w_st && !r_grace) begin
                                w_state = S_FAULT;
                                w_code  = E_UNSOL_BUSY;
                            end else if (w_st) begin
                                w_state = S_ARMED;
                                w_tmr   = '0;
                                w_lat   = LAT_W'(1);
                            end
                        end
                        S_ARMED: begin
                            if (w_st) begin
                                w_state = S_FAULT;
                                w_code  = E_START_ACT;
                            end else if (!w_bz && w_tinc == START_LIM) begin
                                w_state = S_FAULT;
                                w_code  = E_BUSY_TO;
                            end else if (w_iq) begin
                                w_state = S_FAULT;
                                w_code  = E_SPUR_IRQ;
                            end else if (w_bz) begin
                                w_state = S_BUSY;
                                w_tmr   = '0;
                                w_lat   = w_linc;
                            end else begin
                                w_tmr = w_tinc;
                                w_lat = w_linc;
                            end
                        end
                        S_BUSY: begin
                            if (w_st) begin
                                w_state = S_FAULT;
                                w_code  = E_START_ACT;
                            end else if (w_iq) begin
                                w_state = S_IDLE;
                                w_done  = 1'b1;
                                w_grace = 1'b1;
                                w_tmr   = '0;
                            end else if (w_tinc == RUN_LIM) begin
                                w_state = S_FAULT;
                                w_code  = E_RUN_TO;
                            end else if (!w_bz) begin
                                w_state = S_FAULT;
                                w_code  = E_BUSY_DROP;
                            end else begin
                                w_tmr = w_tinc;
                                w_lat = w_linc;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= S_IDLE;
                    r_tmr   <= '0;
                    r_lat   <= '0;
                    r_code  <= '0;
                    r_grace <= 1'b1;  // busy left over from before reset gets one cycle
                    r_cnt   <= '0;
                    r_last  <= '0;
                    r_err   <= 1'b0;
                    r_act   <= 1'b0;
                end else begin
                    r_state <= w_state;
                    r_tmr   <= w_tmr;
                    r_lat   <= w_lat;
                    r_code  <= w_code;
                    r_grace <= w_grace;
                    r_err   <= (w_state == S_FAULT);
                    r_act   <= (w_state == S_ARMED) || (w_state == S_BUSY);
                    if (w_done) begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_last <= r_lat;
                    end
                end
            end

            assign w_err_nx[g]                         = (w_state == S_FAULT);
            assign mon.ch_active_o[g]                  = r_act;
            assign mon.ch_err_o[g]                     = r_err;
            assign mon.ch_err_code_o[3*g +: 3]         = r_code;
            assign mon.done_cnt_o[CNT_W*g +: CNT_W]    = r_cnt;
            assign mon.last_lat_o[LAT_W*g +: LAT_W]    = r_last;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) r_any <= 1'b0;
        else       r_any <= |w_err_nx;
    end

    assign mon.any_err_o = r_any;
endmodule

// File: tb/tb_pp_task_monitor.sv
// Bench for pp_task_monitor: two instances (default and narrow counters / short
// run timeout) driven in lockstep and compared every cycle against a reference model.
module tb_pp_task_monitor;
    localparam int NCH = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pp_task_monitor_if #(.NUM_CH(NCH), .CNT_W(16), .LAT_W(12)) bus_a ();
    pp_task_monitor_if #(.NUM_CH(NCH), .CNT_W(2),  .LAT_W(4))  bus_b ();

    pp_task_monitor #(.NUM_CH(NCH), .START_TO(8), .RUN_TO(1024), .CNT_W(16), .LAT_W(12))
        dut_a (.clk(clk), .reset(reset), .mon(bus_a));
    pp_task_monitor #(.NUM_CH(NCH), .START_TO(8), .RUN_TO(32), .CNT_W(2), .LAT_W(4))
        dut_b (.clk(clk), .reset(reset), .mon(bus_b));

    logic [NCH-1:0] t_st, t_bz, t_iq, t_clr;
    assign bus_a.ch_start_i = t_st;
    assign bus_a.ch_busy_i  = t_bz;
    assign bus_a.ch_irq_i   = t_iq;
    assign bus_a.err_clr_i  = t_clr;
    assign bus_b.ch_start_i = t_st;
    assign bus_b.ch_busy_i  = t_bz;
    assign bus_b.ch_irq_i   = t_iq;
    assign bus_b.err_clr_i  = t_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: phase 0 idle, 1 armed, 2 busy, 3 fault; times are absolute cycles.
    int m_ph   [2][NCH];
    int m_ts   [2][NCH];
    int m_tb   [2][NCH];
    int m_code [2][NCH];
    int m_done [2][NCH];
    int m_last [2][NCH];
    bit m_gr   [2][NCH];

    function automatic int run_to(int d); return d ? 32 : 1024; endfunction
    function automatic int lat_max(int d); return d ? 15 : 4095; endfunction
    function automatic int cnt_mod(int d); return d ? 4 : 65536; endfunction
    function automatic int lowest(int v, int x); return (v == 0 || x < v) ? x : v; endfunction

    function automatic void mstep(int d, int c, bit s, bit b, bit q, bit k);
        bit g;
        int v;
        int el;
        g = m_gr[d][c];
        m_gr[d][c] = 1'b0;
        v = 0;
        if (k) begin
            m_ph[d][c]   = 0;
            m_code[d][c] = 0;
            return;
        end
        case (m_ph[d][c])
            0: begin
                if (q) v = lowest(v, 4);
                if (b && !s && !g) v = lowest(v, 6);
                if (v == 0 && s) begin m_ph[d][c] = 1; m_ts[d][c] = cyc; end
            end
            1: begin
                if (s) v = lowest(v, 1);
                if (!b && cyc - m_ts[d][c] == 8) v = lowest(v, 2);
                if (q) v = lowest(v, 4);
                if (v == 0 && b) begin m_ph[d][c] = 2; m_tb[d][c] = cyc; end
            end
            2: begin
                if (s) v = lowest(v, 1);
                if (!q && cyc - m_tb[d][c] == run_to(d)) v = lowest(v, 3);
                if (!b && !q) v = lowest(v, 5);
                if (v == 0 && q) begin
                    m_done[d][c] = (m_done[d][c] + 1) % cnt_mod(d);
                    el = cyc - m_ts[d][c];
                    m_last[d][c] = (el > lat_max(d)) ? lat_max(d) : el;
                    m_ph[d][c] = 0;
                    m_gr[d][c] = 1'b1;
                end
            end
            default: ;
        endcase
        if (v != 0) begin
            m_ph[d][c]   = 3;
            m_code[d][c] = v;
        end
    endfunction

    function automatic void model_step();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
                if (reset) begin
                    m_ph[d][c] = 0; m_code[d][c] = 0; m_done[d][c] = 0;
                    m_last[d][c] = 0; m_gr[d][c] = 1'b1;
                end else begin
                    mstep(d, c, t_st[c], t_bz[c], t_iq[c], t_clr[c]);
                end
            end
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d expected %0d (cycle %0d)", nm, idx, act, exp, cyc);
        end
    endtask

    task automatic check_all();
        logic any_a, any_b;
        any_a = 1'b0;
        any_b = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            chk("A.active", c, 32'(bus_a.ch_active_o[c]), 32'(m_ph[0][c] == 1 || m_ph[0][c] == 2));
            chk("A.err",    c, 32'(bus_a.ch_err_o[c]),    32'(m_ph[0][c] == 3));
            chk("A.code",   c, 32'(bus_a.ch_err_code_o[3*c +: 3]), m_code[0][c]);
            chk("A.done",   c, 32'(bus_a.done_cnt_o[16*c +: 16]),  m_done[0][c]);
            chk("A.lat",    c, 32'(bus_a.last_lat_o[12*c +: 12]),  m_last[0][c]);
            chk("B.active", c, 32'(bus_b.ch_active_o[c]), 32'(m_ph[1][c] == 1 || m_ph[1][c] == 2));
            chk("B.err",    c, 32'(bus_b.ch_err_o[c]),    32'(m_ph[1][c] == 3));
            chk("B.code",   c, 32'(bus_b.ch_err_code_o[3*c +: 3]), m_code[1][c]);
            chk("B.done",   c, 32'(bus_b.done_cnt_o[2*c +: 2]),    m_done[1][c]);
            chk("B.lat",    c, 32'(bus_b.last_lat_o[4*c +: 4]),    m_last[1][c]);
            any_a |= (m_ph[0][c] == 3);
            any_b |= (m_ph[1][c] == 3);
        end
        chk("A.any", 0, 32'(bus_a.any_err_o), 32'(any_a));
        chk("B.any", 0, 32'(bus_b.any_err_o), 32'(any_b));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic drv(input logic [NCH-1:0] s, input logic [NCH-1:0] b,
                       input logic [NCH-1:0] q, input logic [NCH-1:0] k);
        t_st = s; t_bz = b; t_iq = q; t_clr = k;
        tick();
    endtask

    task automatic do_reset();
        t_st = '0; t_bz = '0; t_iq = '0; t_clr = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    typedef struct {
        bit s, b, q, k;
        int act, err, code, done, last;
    } vec_t;
    vec_t tv[$];

    function automatic void addv(bit s, bit b, bit q, bit k, int act, int err, int code, int done, int last);
        vec_t v;
        v = '{s, b, q, k, act, err, code, done, last};
        tv.push_back(v);
    endfunction

    logic [NCH-1:0] r_bz;

    initial begin
        t_st = '0; t_bz = '0; t_iq = '0; t_clr = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst.active", 0, 32'(bus_a.ch_active_o), 0);
        chk("rst.err",    0, 32'(bus_a.ch_err_o), 0);
        chk("rst.code",   0, 32'(bus_a.ch_err_code_o), 0);
        chk("rst.done",   0, 32'(bus_a.done_cnt_o[15:0]), 0);
        chk("rst.lat",    0, 32'(bus_a.last_lat_o[11:0]), 0);
        chk("rst.any",    0, 32'(bus_a.any_err_o), 0);
        tick();

        // Channel 0 vectors: s b q clr | active err code done last
        addv(1,0,0,0, 1,0,0,0,0);
        addv(0,1,0,0, 1,0,0,0,0);
        addv(0,1,0,0, 1,0,0,0,0);
        addv(0,1,1,0, 0,0,0,1,3);
        addv(0,1,0,0, 0,0,0,1,3);
        addv(0,0,0,0, 0,0,0,1,3);
        addv(1,0,0,0, 1,0,0,1,3);
        addv(0,1,0,0, 1,0,0,1,3);
        addv(1,1,1,0, 0,1,1,1,3);
        addv(0,0,0,0, 0,1,1,1,3);
        addv(0,1,1,0, 0,1,1,1,3);
        addv(0,0,0,1, 0,0,0,1,3);
        addv(0,0,1,0, 0,1,4,1,3);
        addv(1,0,0,1, 0,0,0,1,3);
        addv(0,1,0,0, 0,1,6,1,3);
        addv(0,0,0,1, 0,0,0,1,3);
        addv(1,0,0,0, 1,0,0,1,3);
        addv(1,0,0,0, 0,1,1,1,3);
        addv(0,0,0,1, 0,0,0,1,3);
        addv(1,1,0,0, 1,0,0,1,3);
        addv(0,0,0,0, 1,0,0,1,3);
        addv(0,1,0,0, 1,0,0,1,3);
        addv(0,0,0,0, 0,1,5,1,3);
        addv(0,0,0,1, 0,0,0,1,3);
        addv(1,0,0,0, 1,0,0,1,3);
        addv(0,0,1,0, 0,1,4,1,3);
        addv(0,0,0,1, 0,0,0,1,3);
        foreach (tv[i]) begin
            drv({2'b00, tv[i].s}, {2'b00, tv[i].b}, {2'b00, tv[i].q}, {2'b00, tv[i].k});
            chk("tv.active", i, 32'(bus_a.ch_active_o[0]),       tv[i].act);
            chk("tv.err",    i, 32'(bus_a.ch_err_o[0]),          tv[i].err);
            chk("tv.code",   i, 32'(bus_a.ch_err_code_o[2:0]),   tv[i].code);
            chk("tv.done",   i, 32'(bus_a.done_cnt_o[15:0]),     tv[i].done);
            chk("tv.lat",    i, 32'(bus_a.last_lat_o[11:0]),     tv[i].last);
            chk("tv.any",    i, 32'(bus_a.any_err_o),            tv[i].err);
            chk("tv.B.code", i, 32'(bus_b.ch_err_code_o[2:0]),   tv[i].code);
        end

        // Normal task on channel 0: irq ten cycles after start
        do_reset();
        drv(3'b001, 3'b000, 3'b000, 3'b000);
        repeat (9) drv(3'b000, 3'b001, 3'b000, 3'b000);
        drv(3'b000, 3'b001, 3'b001, 3'b000);
        chk("norm.done", 0, 32'(bus_a.done_cnt_o[15:0]), 1);
        chk("norm.lat",  0, 32'(bus_a.last_lat_o[11:0]), 10);
        chk("norm.err",  0, 32'(bus_a.ch_err_o), 0);
        drv(3'b000, 3'b000, 3'b000, 3'b000);

        // Busy timeout on channel 1, and busy exactly at start+8 being legal on channel 0
        do_reset();
        drv(3'b010, 3'b000, 3'b000, 3'b000);
        repeat (7) drv(3'b000, 3'b000, 3'b000, 3'b000);
        chk("bto.early", 1, 32'(bus_a.ch_err_o[1]), 0);
        drv(3'b000, 3'b000, 3'b000, 3'b000);
        chk("bto.err",   1, 32'(bus_a.ch_err_o[1]), 1);
        chk("bto.code",  1, 32'(bus_a.ch_err_code_o[5:3]), 2);
        chk("bto.ch0",   0, 32'(bus_a.ch_err_o[0]), 0);
        do_reset();
        drv(3'b001, 3'b000, 3'b000, 3'b000);
        repeat (7) drv(3'b000, 3'b000, 3'b000, 3'b000);
        drv(3'b000, 3'b001, 3'b000, 3'b000);
        chk("bto.edge.act", 0, 32'(bus_a.ch_active_o[0]), 1);
        chk("bto.edge.err", 0, 32'(bus_a.ch_err_o[0]), 0);
        drv(3'b000, 3'b001, 3'b001, 3'b000);

        // Back-to-back completions on channel 2 with busy high in each grace cycle
        do_reset();
        repeat (3) begin
            drv(3'b100, 3'b000, 3'b000, 3'b000);
            drv(3'b000, 3'b100, 3'b000, 3'b000);
            drv(3'b000, 3'b100, 3'b000, 3'b000);
            drv(3'b000, 3'b100, 3'b100, 3'b000);
            drv(3'b000, 3'b100, 3'b000, 3'b000);
        end
        chk("b2b.done", 2, 32'(bus_a.done_cnt_o[47:32]), 3);
        chk("b2b.lat",  2, 32'(bus_a.last_lat_o[35:24]), 3);
        chk("b2b.err",  2, 32'(bus_a.ch_err_o[2]), 0);
        drv(3'b000, 3'b000, 3'b000, 3'b000);

        // Latency saturation and done-counter wrap on the narrow instance
        do_reset();
        drv(3'b001, 3'b000, 3'b000, 3'b000);
        repeat (19) drv(3'b000, 3'b001, 3'b000, 3'b000);
        drv(3'b000, 3'b001, 3'b001, 3'b000);
        chk("sat.B.lat", 0, 32'(bus_b.last_lat_o[3:0]), 15);
        chk("sat.A.lat", 0, 32'(bus_a.last_lat_o[11:0]), 20);
        repeat (4) begin
            drv(3'b001, 3'b000, 3'b000, 3'b000);
            drv(3'b000, 3'b001, 3'b000, 3'b000);
            drv(3'b000, 3'b001, 3'b001, 3'b000);
            drv(3'b000, 3'b000, 3'b000, 3'b000);
        end
        chk("wrap.B.done", 0, 32'(bus_b.done_cnt_o[1:0]), 1);
        chk("wrap.A.done", 0, 32'(bus_a.done_cnt_o[15:0]), 5);

        // Run timeout: irq exactly at entry+RUN_TO is legal, one more busy cycle is not
        do_reset();
        drv(3'b001, 3'b000, 3'b000, 3'b000);
        drv(3'b000, 3'b001, 3'b000, 3'b000);
        repeat (31) drv(3'b000, 3'b001, 3'b000, 3'b000);
        drv(3'b000, 3'b001, 3'b001, 3'b000);
        chk("rto.B.done", 0, 32'(bus_b.done_cnt_o[1:0]), 1);
        chk("rto.B.ok",   0, 32'(bus_b.ch_err_o[0]), 0);
        drv(3'b000, 3'b000, 3'b000, 3'b000);
        drv(3'b001, 3'b000, 3'b000, 3'b000);
        drv(3'b000, 3'b001, 3'b000, 3'b000);
        repeat (31) drv(3'b000, 3'b001, 3'b000, 3'b000);
        chk("rto.B.early", 0, 32'(bus_b.ch_err_o[0]), 0);
        drv(3'b000, 3'b001, 3'b000, 3'b000);
        chk("rto.B.err",  0, 32'(bus_b.ch_err_o[0]), 1);
        chk("rto.B.code", 0, 32'(bus_b.ch_err_code_o[2:0]), 3);
        repeat (991) drv(3'b000, 3'b001, 3'b000, 3'b000);
        chk("rto.A.early", 0, 32'(bus_a.ch_err_o[0]), 0);
        drv(3'b000, 3'b001, 3'b000, 3'b000);
        chk("rto.A.code", 0, 32'(bus_a.ch_err_code_o[2:0]), 3);

        // Reset while channel 1 busy and channel 0 faulted
        do_reset();
        drv(3'b000, 3'b000, 3'b001, 3'b000);
        drv(3'b010, 3'b000, 3'b000, 3'b000);
        drv(3'b000, 3'b010, 3'b000, 3'b000);
        chk("mid.err0", 0, 32'(bus_a.ch_err_o[0]), 1);
        chk("mid.act1", 1, 32'(bus_a.ch_active_o[1]), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid.rst.act",  0, 32'(bus_a.ch_active_o), 0);
        chk("mid.rst.err",  0, 32'(bus_a.ch_err_o), 0);
        chk("mid.rst.code", 0, 32'(bus_a.ch_err_code_o), 0);
        chk("mid.rst.any",  0, 32'(bus_a.any_err_o), 0);
        tick();
        chk("mid.grace", 1, 32'(bus_a.ch_err_o[1]), 0);
        drv(3'b000, 3'b000, 3'b000, 3'b000);
        chk("mid.release", 1, 32'(bus_a.ch_err_o[1]), 0);
        t_bz = 3'b010;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("mid.hold.err",  1, 32'(bus_a.ch_err_o[1]), 1);
        chk("mid.hold.code", 1, 32'(bus_a.ch_err_code_o[5:3]), 6);

        // Randomized traffic, checked every cycle against the model
        do_reset();
        r_bz = '0;
        for (int i = 0; i < 4000; i++) begin
            logic [NCH-1:0] s, q, k;
            for (int c = 0; c < NCH; c++) begin
                s[c] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 4) == 0) r_bz[c] = ~r_bz[c];
                q[c] = r_bz[c] ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
                k[c] = ($urandom_range(0, 29) == 0);
            end
            reset = ($urandom_range(0, 499) == 0);
            drv(s, r_bz, q, k);
            reset = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
